// File: rtl/ccff_chain_loader.sv
// Configuration-chain loader: gathers bitstream words into a buffer, then shifts them
// serially into a gated-clock CCFF chain, with an optional readback pass that compares the tail.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 48,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              start,
  input  logic              verify_en,
  input  logic [WORD_W-1:0] bs_data,
  input  logic              bs_valid,
  output logic              bs_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              cfg_clk_en,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int NWORDS = CHAIN_LEN / WORD_W;
  localparam int BCW    = $clog2(CHAIN_LEN) + 1;
  localparam int WCW    = $clog2(NWORDS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_SHIFT,
    S_VERIFY,
    S_DONE
  } state_t;

  state_t               r_state;
  logic [CHAIN_LEN-1:0] r_buf;
  logic [WCW-1:0]       r_wcnt;
  logic [BCW-1:0]       r_bcnt;
  logic                 r_verify;
  logic                 r_bs_ready;
  logic                 r_head;
  logic                 r_cfg_en;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_error;

  logic [CHAIN_LEN-1:0] w_fill_buf;
  logic [CHAIN_LEN-1:0] w_rot_buf;
  logic                 w_xfer;
  logic                 w_last_word;
  logic                 w_last_bit;

  assign w_fill_buf  = {r_buf[CHAIN_LEN-WORD_W-1:0], bs_data};
  assign w_rot_buf   = {r_buf[CHAIN_LEN-2:0], r_buf[CHAIN_LEN-1]};
  assign w_xfer      = bs_valid & r_bs_ready;
  assign w_last_word = (r_wcnt == WCW'(NWORDS - 1));
  assign w_last_bit  = (r_bcnt == BCW'(CHAIN_LEN - 1));

  assign bs_ready   = r_bs_ready;
  assign ccff_head  = r_head;
  assign cfg_clk_en = r_cfg_en;
  assign busy       = r_busy;
  assign done       = r_done;
  assign error      = r_error;

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      r_state    <= S_IDLE;
      r_buf      <= '0;
      r_wcnt     <= '0;
      r_bcnt     <= '0;
      r_verify   <= 1'b0;
      r_bs_ready <= 1'b0;
      r_head     <= 1'b0;
      r_cfg_en   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_FILL;
            r_verify   <= verify_en;
            r_error    <= 1'b0;
            r_wcnt     <= '0;
            r_bcnt     <= '0;
            r_bs_ready <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        S_FILL: begin
          if (w_xfer) begin
            r_buf  <= w_fill_buf;
            r_wcnt <= r_wcnt + WCW'(1);
            r_head <= w_fill_buf[CHAIN_LEN-1];
            // Enable goes high together with the state change so the chain sees no gap
            if (w_last_word) begin
              r_state    <= S_SHIFT;
              r_bs_ready <= 1'b0;
              r_cfg_en   <= 1'b1;
            end
          end
        end
        S_SHIFT, S_VERIFY: begin
          r_buf  <= w_rot_buf;
          r_head <= r_buf[CHAIN_LEN-2];
          if (r_state == S_VERIFY && ccff_tail != r_buf[CHAIN_LEN-1]) begin
            r_error <= 1'b1;
          end
          // A full rotation restores the post-fill buffer, so VERIFY replays the same bits
          if (w_last_bit) begin
            r_bcnt <= '0;
            if (r_state == S_SHIFT && r_verify) begin
              r_state <= S_VERIFY;
            end else begin
              r_state  <= S_DONE;
              r_cfg_en <= 1'b0;
              r_done   <= 1'b1;
            end
          end else begin
            r_bcnt <= r_bcnt + BCW'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: a behavioural 48-bit chain plus a bitstream-order model
// checked every cycle, and directed load / verify / stall / reset / re-trigger scenarios.
module tb_ccff_chain_loader;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       verify_en;
  logic [7:0] bs_data;
  logic       bs_valid;
  logic       bs_ready;
  logic       ccff_head;
  logic       ccff_tail;
  logic       cfg_clk_en;
  logic       busy;
  logic       done;
  logic       error;

  ccff_chain_loader #(.CHAIN_LEN(48), .WORD_W(8)) dut (
    .prog_clk  (clk),
    .pReset_n  (rst_n),
    .start     (start),
    .verify_en (verify_en),
    .bs_data   (bs_data),
    .bs_valid  (bs_valid),
    .bs_ready  (bs_ready),
    .ccff_head (ccff_head),
    .ccff_tail (ccff_tail),
    .cfg_clk_en(cfg_clk_en),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  words [6] = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81, 8'h7E};
  logic [47:0] exp_bits;
  logic [47:0] chain = '0;
  int          pos_en = 0;
  int          base_pos, base_en, base_rdy, base_done, base_runs;
  int          tot_en, tot_rdy, tot_done, tot_runs;
  logic        prev_en;
  logic        inj_on;
  int          n_checks, n_errors;

  // Behavioural chain: shifts head in at position 0, tail is the far end
  always @(posedge clk) begin
    if (cfg_clk_en) begin
      chain  <= {chain[46:0], ccff_head};
      pos_en <= pos_en + 1;
    end
  end
  assign ccff_tail = chain[47] ^ (inj_on && (pos_en - base_pos == 65));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_word(input bit tog, inout int idx, inout int rc);
    if (bs_ready) begin
      bs_valid = tog ? (rc % 2 == 0) : 1'b1;
      rc++;
    end else begin
      bs_valid = 1'b1;
    end
    bs_data = (idx < 6) ? words[idx] : 8'hEE;
    if (bs_valid && bs_ready) idx++;
  endtask

  task automatic do_seq(input bit v, input bit tog, input bit inj, input bit midstart,
                        input bit exp_err, input bit prestarted);
    int  idx = 0;
    int  rc = 0;
    bit  fin = 0;
    if (!prestarted) begin
      @(posedge clk); #1;
      start     = 1'b1;
      verify_en = v;
    end
    base_en   = tot_en;
    base_rdy  = tot_rdy;
    base_done = tot_done;
    base_runs = tot_runs;
    base_pos  = pos_en;
    inj_on    = inj;
    if (!prestarted) begin
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("fill_entry_ready", bs_ready, 1'b1);
    chk("fill_entry_busy", busy, 1'b1);
    chk("start_clears_error", error, 1'b0);
    for (int c = 0; c < 400 && !fin; c++) begin
      if (done) begin
        fin = 1;
      end else begin
        drive_word(tog, idx, rc);
        if (midstart && (tot_en - base_en == 10)) start = 1'b1;
        @(posedge clk); #1;
      end
    end
    chk("seq_timeout", fin, 1'b1);
    @(negedge clk);
    chk("ready_cycles", tot_rdy - base_rdy, tog ? 11 : 6);
    chk("enabled_cycles", tot_en - base_en, v ? 96 : 48);
    chk("enable_runs", tot_runs - base_runs, 1);
    chk("done_pulses", tot_done - base_done, 1);
    chk("error_flag", error, exp_err);
    chk("chain_content", chain, 48'hA53CFF00817E);
    inj_on = 1'b0;
  endtask

  task automatic reset_mid();
    int idx = 0;
    int rc = 0;
    bit hit = 0;
    @(posedge clk); #1;
    start     = 1'b1;
    verify_en = 1'b1;
    base_en   = tot_en;
    base_done = tot_done;
    base_pos  = pos_en;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 200 && !hit; c++) begin
      if (tot_en - base_en == 20) begin
        hit = 1;
      end else begin
        drive_word(1'b0, idx, rc);
        @(posedge clk); #1;
      end
    end
    chk("reset_point_reached", hit, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ready", bs_ready, 1'b0);
    chk("rst_mid_en", cfg_clk_en, 1'b0);
    chk("rst_mid_head", ccff_head, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_done", done, 1'b0);
    chk("rst_mid_error", error, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_no_done", tot_done - base_done, 0);
    chk("rst_stays_idle", busy, 1'b0);
  endtask

  initial begin
    rst_n = 1'b1;
    start = 1'b0;
    verify_en = 1'b0;
    bs_valid = 1'b0;
    bs_data = '0;
    inj_on = 1'b0;
    base_pos = 0; base_en = 0; base_rdy = 0; base_done = 0; base_runs = 0;
    tot_en = 0; tot_rdy = 0; tot_done = 0; tot_runs = 0;
    prev_en = 1'b0;
    n_checks = 0;
    n_errors = 0;
    for (int j = 0; j < 48; j++) exp_bits[j] = words[j / 8][7 - (j % 8)];
    #1 rst_n = 1'b0;

    // Per-cycle observer: head must follow the bitstream MSB-first during every enabled pass
    fork
      forever begin
        @(negedge clk);
        if (rst_n) begin
          if (cfg_clk_en) begin
            chk("head_bit", ccff_head, exp_bits[(tot_en - base_en) % 48]);
            tot_en++;
            if (!prev_en) tot_runs++;
          end
          if (bs_ready) tot_rdy++;
          if (bs_ready || cfg_clk_en) chk("ready_en_exclusive", bs_ready & cfg_clk_en, 1'b0);
          if (done) tot_done++;
          prev_en = cfg_clk_en;
        end else begin
          prev_en = 1'b0;
        end
      end
    join_none

    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", bs_ready, 1'b0);
    chk("reset_en", cfg_clk_en, 1'b0);
    chk("reset_head", ccff_head, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_error", error, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    do_seq(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_seq(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_seq(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    do_seq(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    reset_mid();
    do_seq(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    verify_en = 1'b0;
    do_seq(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("retrigger_idle_busy", busy, 1'b0);
    chk("retrigger_idle_ready", bs_ready, 1'b0);
    chk("retrigger_idle_done", done, 1'b0);
    @(posedge clk); #1;
    do_seq(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ccff_chain_loader.md
CCFF_CHAIN_LOADER -- requirements
Module: ccff_chain_loader

Interface
REQ-001 Parameter CHAIN_LEN, default 48: configuration chain length in bits (8 muxes x 6 SRAM bits); SHALL be a multiple of WORD_W.
REQ-002 Parameter WORD_W, default 8: bitstream word width; NWORDS = CHAIN_LEN/WORD_W.
REQ-003 prog_clk  input  1  programming clock; all state on its rising edge.
REQ-004 pReset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  begin a load sequence; honoured only in IDLE.
REQ-006 verify_en  input  1  sampled with start; 1 = run readback pass after load.
REQ-007 bs_data  input  WORD_W  bitstream word.
REQ-008 bs_valid  input  1  bs_data valid.
REQ-009 bs_ready  output  1  loader accepts word; transfer = bs_valid & bs_ready.
REQ-010 ccff_head  output  1  serial config bit to chain head.
REQ-011 ccff_tail  input  1  serial bit returned from chain tail.
REQ-012 cfg_clk_en  output  1  enable to the external prog_clk gate of the chain; chain shifts only on edges where it is 1.
REQ-013 busy  output  1  state != IDLE.
REQ-014 done  output  1  one-cycle pulse at sequence end.
REQ-015 error  output  1  readback mismatch flag; sticky until next accepted start.

Function
REQ-016 States: IDLE, FILL, SHIFT, VERIFY, DONE; state and all outputs derived from registers.
REQ-017 IDLE: bs_ready=0, cfg_clk_en=0; start=1 -> FILL next edge; latch verify_en; clear error, word counter, bit counter.
REQ-018 FILL: bs_ready=1; each transfer shifts a buffer of CHAIN_LEN bits left by WORD_W, inserting bs_data at LSBs; word counter +1.
REQ-019 FILL: on the transfer that brings the word count to NWORDS -> SHIFT; bs_ready deasserts the following cycle; bs_valid while not in FILL ignored.
REQ-020 Bit order: bs_data[WORD_W-1] of word 0 is the first bit shifted, ending at the tail-most chain position.
REQ-021 SHIFT: cfg_clk_en=1 for exactly CHAIN_LEN consecutive cycles, no gaps; ccff_head = buffer MSB; buffer rotates left by 1 each cycle (MSB re-enters at LSB).
REQ-022 After CHAIN_LEN SHIFT cycles the buffer equals its post-FILL value; -> VERIFY if latched verify_en=1, else DONE.
REQ-023 VERIFY: identical to SHIFT (cfg_clk_en=1, same rotate, CHAIN_LEN cycles); each cycle compare ccff_tail with buffer MSB; any mismatch sets error.
REQ-024 VERIFY re-writes identical data; chain content after VERIFY equals content after SHIFT.
REQ-025 DONE: done=1 for one cycle, cfg_clk_en=0, -> IDLE.
REQ-026 Bit counter: log2(CHAIN_LEN)+1 bits, wraps to 0 on SHIFT->VERIFY transition; no off-by-one: exactly CHAIN_LEN enabled edges per pass.
REQ-027 start asserted while busy SHALL be ignored; start held high through DONE re-triggers only from IDLE (one cycle after done).
REQ-028 bs_valid low in FILL stalls with no timeout; cfg_clk_en remains 0 during stalls.

Reset
REQ-029 pReset_n=0 asynchronously forces IDLE; bs_ready=0, cfg_clk_en=0, ccff_head=0, done=0, error=0, busy=0, counters and buffer 0.
REQ-030 Reset mid-SHIFT/VERIFY aborts immediately; chain content undefined, no done pulse; new start required after release.
REQ-031 Release of pReset_n is synchronous to prog_clk externally; first start honoured on the first edge after release.

Verification
REQ-032 Load 6 words 0xA5,0x3C,0xFF,0x00,0x81,0x7E, verify_en=0, bs_valid always 1 -> bs_ready high 6 cycles, cfg_clk_en high exactly 48 cycles, ccff_head sequence = bitstream MSB-first, done pulse, error=0.
REQ-033 Same load with behavioural 48-bit chain model and verify_en=1 -> 96 enabled cycles, model holds loaded bits, error=0.
REQ-034 verify_en=1 with model tail bit 17 forced inverted -> error=1 after VERIFY, done still pulses, error clears on next start.
REQ-035 bs_valid toggled 1/0 every other cycle -> FILL takes 11 cycles, cfg_clk_en 0 throughout FILL, SHIFT still 48 contiguous cycles.
REQ-036 pReset_n low at SHIFT cycle 20 -> outputs at reset values same cycle, no done; after release, full load succeeds with error=0.
REQ-037 start pulsed during SHIFT and held through DONE -> mid-run start ignored; new FILL begins the cycle after IDLE is re-entered.
